// File: rtl/zynq_axi3_mem_responder.sv
// AXI3 burst memory responder: one write and one read burst served concurrently from a word array.
// Optional LFSR-driven wready/rvalid stalls when ZYNQ_AXI_MEM_RANDOM_STALL_EN is defined.
module zynq_axi3_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int ID_WIDTH           = 6,
    parameter int MEM_ELS            = 1024
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]             s_axi_awid,
    input  logic [3:0]                      s_axi_awlen,
    input  logic [2:0]                      s_axi_awsize,
    input  logic [1:0]                      s_axi_awburst,
    input  logic [1:0]                      s_axi_awlock,
    input  logic [3:0]                      s_axi_awcache,
    input  logic [2:0]                      s_axi_awprot,
    input  logic [3:0]                      s_axi_awqos,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic [ID_WIDTH-1:0]             s_axi_wid,
    input  logic                            s_axi_wlast,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [ID_WIDTH-1:0]             s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]             s_axi_arid,
    input  logic [3:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [1:0]                      s_axi_arburst,
    input  logic [1:0]                      s_axi_arlock,
    input  logic [3:0]                      s_axi_arcache,
    input  logic [2:0]                      s_axi_arprot,
    input  logic [3:0]                      s_axi_arqos,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]             s_axi_rid,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_ELS);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awqos, s_axi_araddr, s_axi_arsize, s_axi_arlock, s_axi_arcache,
                             s_axi_arprot, s_axi_arqos};

    // Keeps both address readies low until the first edge after reset release.
    logic run_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    logic w_stall, r_stall;
`ifdef ZYNQ_AXI_MEM_RANDOM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr_q <= 8'hA5;
        else          lfsr_q <= lfsr_d;
    end
    assign w_stall = lfsr_q[0];
    assign r_stall = lfsr_q[1];
`else
    assign w_stall = 1'b0;
    assign r_stall = 1'b0;
`endif

    // ---------------- write path ----------------
    w_state_e            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [IDX_W-1:0]    w_idx_q, w_idx_d;
    logic [3:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]          w_burst_q, w_burst_d;
    logic                w_err_q, w_err_d;
    logic                aw_hs, w_hs, w_final, w_beat_err, w_we;

    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign w_final    = (w_cnt_q == w_len_q);
    assign w_beat_err = (s_axi_wid != w_id_q) || (s_axi_wlast != w_final) || (w_burst_q == BURST_WRAP);
    assign w_we       = w_hs && (w_burst_q != BURST_WRAP);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_d = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = run_q && (w_state_q == W_IDLE);
        s_axi_wready  = (w_state_q == W_DATA) && !w_stall;
        s_axi_bvalid  = (w_state_q == W_RESP);
        s_axi_bid     = w_id_q;
        s_axi_bresp   = (s_axi_bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    end

    always_comb begin
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        if (aw_hs) begin
            w_id_d    = s_axi_awid;
            w_idx_d   = s_axi_awaddr[OFF_W +: IDX_W];
            w_len_d   = s_axi_awlen;
            w_burst_d = s_axi_awburst;
            w_cnt_d   = 4'd0;
            w_err_d   = 1'b0;
        end else if (w_hs) begin
            w_cnt_d = w_cnt_q + 4'd1;
            if (w_burst_q != BURST_FIXED) w_idx_d = w_idx_q + IDX_W'(1);
            w_err_d = w_err_q || w_beat_err;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // Storage is deliberately not reset.
    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_ELS];
    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e                      r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]           r_id_q, r_id_d;
    logic [IDX_W-1:0]              r_idx_q, r_idx_d;
    logic [3:0]                    r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]                    r_burst_q, r_burst_d;
    logic                          r_vld_q, r_vld_d, r_last_q, r_last_d;
    logic [1:0]                    r_resp_q, r_resp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data_q, r_data_d, rd_raw, rd_word;
    logic                          ar_hs, r_hs, r_hold;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = r_vld_q && s_axi_rready;
    assign r_hold = r_vld_q && !s_axi_rready;

    // A write landing on the same edge as a read capture is forwarded so the beat sees it.
    assign rd_raw = mem[r_idx_d];
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_rd_bypass
        assign rd_word[gi*8 +: 8] = (w_we && s_axi_wstrb[gi] && (w_idx_q == r_idx_d)) ?
                                    s_axi_wdata[gi*8 +: 8] : rd_raw[gi*8 +: 8];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = run_q && (r_state_q == R_IDLE);
        s_axi_rvalid  = r_vld_q;
        s_axi_rdata   = r_data_q;
        s_axi_rid     = r_id_q;
        s_axi_rlast   = r_last_q;
        s_axi_rresp   = r_resp_q;
    end

    always_comb begin
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_vld_d   = r_vld_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_id_d    = s_axi_arid;
                    r_idx_d   = s_axi_araddr[OFF_W +: IDX_W];
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_cnt_d   = 4'd0;
                    r_vld_d   = !r_stall;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_last_q) begin
                        r_vld_d = 1'b0;
                    end else begin
                        r_cnt_d = r_cnt_q + 4'd1;
                        if (r_burst_q != BURST_FIXED) r_idx_d = r_idx_q + IDX_W'(1);
                        r_vld_d = !r_stall;
                    end
                end else if (!r_vld_q) begin
                    r_vld_d = !r_stall;
                end
            end
            default: r_vld_d = 1'b0;
        endcase
    end

    // Beat payload is captured when the beat is (re)presented and frozen while stalled.
    always_comb begin
        r_data_d = '0;
        r_last_d = 1'b0;
        r_resp_d = RESP_OKAY;
        if (r_hold) begin
            r_data_d = r_data_q;
            r_last_d = r_last_q;
            r_resp_d = r_resp_q;
        end else if (r_vld_d) begin
            r_data_d = rd_word;
            r_last_d = (r_cnt_d == r_len_d);
            r_resp_d = (r_burst_d == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_vld_q   <= 1'b0;
            r_last_q  <= 1'b0;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
        end else begin
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_vld_q   <= r_vld_d;
            r_last_q  <= r_last_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

endmodule
